bcd_7seg_scan_driver: RTL and testbench
=======================================

Name: bcd_7seg_scan_driver

Overview:
- Drives a multiplexed bank of DIGITS seven-segment digits from packed BCD.
- One digit is lit at a time, cycling through all digits at a rate set by REFRESH_DIV.
- Supports a shadow load register, per-digit decimal points, leading-zero blanking, a "-" glyph for invalid codes, and selectable common-anode/cathode polarity.
- Sits between the BCD datapath (counters, converters) and the board display pins.

Parameters:
- DIGITS, 4: number of digits scanned; legal range 1..8.
- REFRESH_DIV, 1000: clock cycles each digit stays lit; legal values >= 1.
- COMMON_ANODE, 0: 0 = segment, dp and digit enables are active-high; 1 = all of them are active-low.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bcd_in  input  4*DIGITS  packed BCD; digit k is bcd_in[4k+3:4k]; digit 0 is least significant.
- dp_in  input  DIGITS  decimal-point request per digit.
- load  input  1  capture bcd_in and dp_in into the shadow registers.
- blank_lz  input  1  enable leading-zero blanking.
- seg  output  7  segments {a,b,c,d,e,f,g}; a is bit 6, g is bit 0.
- dp  output  1  decimal-point segment.
- an  output  DIGITS  one-hot digit enable.
- digit_idx  output  $clog2(DIGITS) (min 1)  index of the digit currently shown on an.

Behaviour:
Reset (rst_n low, asynchronous):
- Refresh counter = 0, internal index = 0, shadow BCD = 0, shadow dp = 0, digit_idx = 0.
- seg, dp and an all at inactive level: all 0 when COMMON_ANODE=0, all 1 when COMMON_ANODE=1.

Shadow load:
- On a clock edge with load=1, shadow_bcd <= bcd_in and shadow_dp <= dp_in.
- The display reads only the shadow registers, never bcd_in or dp_in directly.

Refresh counter and index:
- The counter runs 0..REFRESH_DIV-1.
- At the terminal count it returns to 0 and the index advances by one, wrapping from DIGITS-1 to 0.
- REFRESH_DIV=1 advances the index every cycle.
- DIGITS=1 keeps the index at 0 permanently.

Registered outputs:
- seg, dp, an and digit_idx are registered, one-cycle latency.
- Each edge they are computed from the pre-edge index and pre-edge shadow values.
- The first non-idle output appears on the first edge after rst_n deasserts, showing digit 0.
- an has exactly one active bit, at position digit_idx.

Decode for active-high segments {a..g}:
- 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011.
- 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011.
- Codes 10..15 display 0000001 (the "-" glyph); they are never blanked as zero.

Leading-zero blanking (blank_lz=1):
- Digit k is blanked if it and every higher-index digit hold code 0.
- Digit 0 is never blanked.
- A blanked digit shows seg all inactive, but an still selects it and dp still follows shadow_dp[k].

Polarity:
- COMMON_ANODE=1 bitwise-inverts seg, dp and an after decode. digit_idx is unaffected.

Boundary conditions:
- load coinciding with the refresh terminal count: the index advances and the shadow updates on the same edge; the outputs registered on that edge use the old shadow, and new data appears one edge later.
- rst_n asserted mid-scan: all state clears immediately; the scan restarts at digit 0 with a fresh count.
- load held high continuously makes the display track bcd_in with one cycle of shadow delay plus one cycle of output delay.

Test Plan:
All scenarios use DIGITS=4, REFRESH_DIV=4, COMMON_ANODE=0 unless stated.
1. Reset, then load 16'h1234, dp_in=0 → an cycles 0001, 0010, 0100, 1000, each held 4 cycles. seg shows 4=0110011, 3=1111001, 2=1101101, 1=0110000 in that order, then wraps to 0001.
2. Load 16'h0070, blank_lz=1 → digits 3 and 2 show seg=0000000. Digit 1 shows 1110000 and digit 0 shows 1111110. With blank_lz=0, digits 3 and 2 show 1111110.
3. Load 16'h0000 with blank_lz=1 and dp_in=4'b0100 → digit 0 shows 1111110. Digits 3, 2 and 1 are blank, digit 2 shows dp=1, and the other dp values are 0.
4. Load 16'hA5F9 → digits 3 and 1 show 0000001, digit 2 shows 1011011, digit 0 shows 1111011. Repeat with blank_lz=1: identical result.
5. COMMON_ANODE=1 with 16'h1234 → an sequence is 1110, 1101, 1011, 0111. Digit 0 shows seg=1001100. dp=1 when not requested. After reset all outputs are 1.
6. Pulse rst_n low mid-count on digit 2 → outputs are immediately inactive. After release, digit 0 shows on the first edge, shadow reads 0 (seg=1111110 with blank_lz=0), and a later load on the same edge as a terminal count appears one edge after the index change.

Source files
------------

// File: rtl/bcd_7seg_scan_driver_if.sv
// Bundle between the BCD datapath and the scanned seven-segment driver.
// master = the datapath side, slave = the driver.
interface bcd_7seg_scan_driver_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] bcd_in;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                blank_lz;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic [IdxW-1:0]     digit_idx;

    modport master (
        output bcd_in, dp_in, load, blank_lz,
        input  seg, dp, an, digit_idx
    );

    modport slave (
        input  bcd_in, dp_in, load, blank_lz,
        output seg, dp, an, digit_idx
    );
endinterface

// File: rtl/bcd_7seg_scan_driver.sv
// Multiplexed seven-segment scan driver: shadowed BCD, leading-zero blanking,
// "-" for invalid codes, selectable common-anode/cathode polarity.
module bcd_7seg_scan_driver #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned COMMON_ANODE = 0
) (
    input logic                   clk,
    input logic                   rst_n,
    bcd_7seg_scan_driver_if.slave bus
);
    localparam int unsigned     IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned     CntW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);
    localparam logic            Inv    = (COMMON_ANODE != 0);

    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [IdxW-1:0]     digit_idx_q, digit_idx_d;

    logic [DIGITS-1:0]   lz_blank;
    logic                all_zero;
    logic [3:0]          cur_code;
    logic                cur_dp;
    logic                cur_blank;
    logic [6:0]          seg_raw;
    logic [DIGITS-1:0]   an_raw;

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
            default: decode = 7'b0000001;
        endcase
    endfunction

    always_comb begin : next_state
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        if (cnt_q == CntMax) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
        end
        if (bus.load) begin
            shadow_bcd_d = bus.bcd_in;
            shadow_dp_d  = bus.dp_in;
        end
    end

    always_comb begin : display
        lz_blank  = '0;
        all_zero  = 1'b1;
        cur_code  = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_raw    = '0;
        // Walk from the most significant digit down; a zero run from the top is blankable.
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            all_zero    = all_zero && (shadow_bcd_q[4*k +: 4] == 4'd0);
            lz_blank[k] = bus.blank_lz && all_zero && (k != 0);
        end
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (idx_q == IdxW'(k)) begin
                cur_code  = shadow_bcd_q[4*k +: 4];
                cur_dp    = shadow_dp_q[k];
                cur_blank = lz_blank[k];
                an_raw[k] = 1'b1;
            end
        end
        seg_raw     = cur_blank ? 7'b0000000 : decode(cur_code);
        seg_d       = seg_raw ^ {7{Inv}};
        dp_d        = cur_dp ^ Inv;
        an_d        = an_raw ^ {DIGITS{Inv}};
        digit_idx_d = idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            seg_q        <= {7{Inv}};
            dp_q         <= Inv;
            an_q         <= {DIGITS{Inv}};
            digit_idx_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            digit_idx_q  <= digit_idx_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.an        = an_q;
    assign bus.digit_idx = digit_idx_q;
endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Directed bench: a common-cathode and a common-anode instance scanned side by side
// with DIGITS=4, REFRESH_DIV=4.
module tb_bcd_7seg_scan_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks;
    int   errors;

    always #5 clk = ~clk;

    bcd_7seg_scan_driver_if #(.DIGITS(4)) ifa ();
    bcd_7seg_scan_driver_if #(.DIGITS(4)) ifb ();

    bcd_7seg_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .COMMON_ANODE(0)) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifa)
    );

    bcd_7seg_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .COMMON_ANODE(1)) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifb)
    );

    task automatic drive(input logic [15:0] bcd, input logic [3:0] dpv, input logic blz,
                         input logic ld);
        ifa.bcd_in = bcd; ifa.dp_in = dpv; ifa.blank_lz = blz; ifa.load = ld;
        ifb.bcd_in = bcd; ifb.dp_in = dpv; ifb.blank_lz = blz; ifb.load = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then load on edge 1; afterwards bcd_in/dp_in change but must not be shown.
    task automatic start_scan(input logic [15:0] bcd, input logic [3:0] dpv, input logic blz);
        rst_n = 1'b0;
        drive(bcd, dpv, blz, 1'b1);
        #2;
        rst_n = 1'b1;
        tick();
        drive(16'hEEEE, ~dpv, blz, 1'b0);
    endtask

    task automatic test_reset();
        tick();
        if (ifa.seg !== 7'h00) begin errors++; $display("FAIL rst_seg_a got %b want 0000000", ifa.seg); end
        checks++;
        if (ifa.dp !== 1'b0) begin errors++; $display("FAIL rst_dp_a got %b want 0", ifa.dp); end
        checks++;
        if (ifa.an !== 4'b0000) begin errors++; $display("FAIL rst_an_a got %b want 0000", ifa.an); end
        checks++;
        if (ifa.digit_idx !== 2'd0) begin errors++; $display("FAIL rst_idx_a got %0d want 0", ifa.digit_idx); end
        checks++;
        if (ifb.seg !== 7'h7F) begin errors++; $display("FAIL rst_seg_b got %b want 1111111", ifb.seg); end
        checks++;
        if (ifb.dp !== 1'b1) begin errors++; $display("FAIL rst_dp_b got %b want 1", ifb.dp); end
        checks++;
        if (ifb.an !== 4'b1111) begin errors++; $display("FAIL rst_an_b got %b want 1111", ifb.an); end
        checks++;
        if (ifb.digit_idx !== 2'd0) begin errors++; $display("FAIL rst_idx_b got %0d want 0", ifb.digit_idx); end
        checks++;
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        int d;
        exp_seg = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
        start_scan(16'h1234, 4'b0000, 1'b0);
        if (ifa.seg !== 7'b1111110 || ifa.an !== 4'b0001) begin
            errors++; $display("FAIL scan_first seg=%b an=%b want 1111110/0001", ifa.seg, ifa.an);
        end
        checks++;
        for (int n = 2; n <= 17; n++) begin
            tick();
            d = ((n - 1) / 4) % 4;
            exp_an = 4'b0001 << d;
            if (ifa.an !== exp_an) begin errors++; $display("FAIL scan_an n=%0d got %b want %b", n, ifa.an, exp_an); end
            checks++;
            if (ifa.seg !== exp_seg[d]) begin errors++; $display("FAIL scan_seg n=%0d got %b want %b", n, ifa.seg, exp_seg[d]); end
            checks++;
            if (ifa.digit_idx !== 2'(d)) begin errors++; $display("FAIL scan_idx n=%0d got %0d want %0d", n, ifa.digit_idx, d); end
            checks++;
            if (ifa.dp !== 1'b0) begin errors++; $display("FAIL scan_dp n=%0d got %b want 0", n, ifa.dp); end
            checks++;
        end
    endtask

    task automatic test_blanking();
        logic [6:0] exp_seg [4];
        int d;
        for (int r = 0; r < 2; r++) begin
            if (r == 0) exp_seg = '{7'b1111110, 7'b1110000, 7'b0000000, 7'b0000000};
            else        exp_seg = '{7'b1111110, 7'b1110000, 7'b1111110, 7'b1111110};
            start_scan(16'h0070, 4'b0000, (r == 0));
            for (int n = 2; n <= 17; n++) begin
                tick();
                d = ((n - 1) / 4) % 4;
                if (ifa.seg !== exp_seg[d]) begin
                    errors++; $display("FAIL lz_seg r=%0d n=%0d got %b want %b", r, n, ifa.seg, exp_seg[d]);
                end
                checks++;
                if (ifa.an !== (4'b0001 << d)) begin
                    errors++; $display("FAIL lz_an r=%0d n=%0d got %b want %b", r, n, ifa.an, 4'b0001 << d);
                end
                checks++;
            end
        end
    endtask

    task automatic test_dp_blank();
        logic [6:0] exp_seg [4];
        logic       exp_dp;
        int d;
        exp_seg = '{7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000};
        start_scan(16'h0000, 4'b0100, 1'b1);
        for (int n = 2; n <= 17; n++) begin
            tick();
            d = ((n - 1) / 4) % 4;
            exp_dp = (d == 2);
            if (ifa.seg !== exp_seg[d]) begin errors++; $display("FAIL dpz_seg n=%0d got %b want %b", n, ifa.seg, exp_seg[d]); end
            checks++;
            if (ifa.dp !== exp_dp) begin errors++; $display("FAIL dpz_dp n=%0d got %b want %b", n, ifa.dp, exp_dp); end
            checks++;
            if (ifa.an !== (4'b0001 << d)) begin errors++; $display("FAIL dpz_an n=%0d got %b want %b", n, ifa.an, 4'b0001 << d); end
            checks++;
        end
    endtask

    task automatic test_invalid();
        logic [6:0] exp_seg [4];
        int d;
        exp_seg = '{7'b1111011, 7'b0000001, 7'b1011011, 7'b0000001};
        for (int r = 0; r < 2; r++) begin
            start_scan(16'hA5F9, 4'b0000, (r == 1));
            for (int n = 2; n <= 17; n++) begin
                tick();
                d = ((n - 1) / 4) % 4;
                if (ifa.seg !== exp_seg[d]) begin
                    errors++; $display("FAIL inv_seg r=%0d n=%0d got %b want %b", r, n, ifa.seg, exp_seg[d]);
                end
                checks++;
            end
        end
    endtask

    task automatic test_common_anode();
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an [4];
        int d;
        exp_seg = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        start_scan(16'h1234, 4'b0000, 1'b0);
        for (int n = 2; n <= 17; n++) begin
            tick();
            d = ((n - 1) / 4) % 4;
            if (ifb.an !== exp_an[d]) begin errors++; $display("FAIL ca_an n=%0d got %b want %b", n, ifb.an, exp_an[d]); end
            checks++;
            if (ifb.seg !== exp_seg[d]) begin errors++; $display("FAIL ca_seg n=%0d got %b want %b", n, ifb.seg, exp_seg[d]); end
            checks++;
            if (ifb.dp !== 1'b1) begin errors++; $display("FAIL ca_dp n=%0d got %b want 1", n, ifb.dp); end
            checks++;
            if (ifb.digit_idx !== 2'(d)) begin errors++; $display("FAIL ca_idx n=%0d got %0d want %0d", n, ifb.digit_idx, d); end
            checks++;
        end
    endtask

    task automatic test_reset_midscan();
        start_scan(16'h1234, 4'b0000, 1'b0);
        for (int n = 2; n <= 10; n++) tick();
        if (ifa.an !== 4'b0100) begin errors++; $display("FAIL mid_pre_an got %b want 0100", ifa.an); end
        checks++;
        #2;
        rst_n = 1'b0;
        #1;
        if (ifa.seg !== 7'h00 || ifa.an !== 4'b0000 || ifa.dp !== 1'b0 || ifa.digit_idx !== 2'd0) begin
            errors++;
            $display("FAIL mid_rst_a seg=%b an=%b dp=%b idx=%0d want all 0", ifa.seg, ifa.an, ifa.dp, ifa.digit_idx);
        end
        checks++;
        if (ifb.seg !== 7'h7F || ifb.an !== 4'b1111 || ifb.dp !== 1'b1) begin
            errors++; $display("FAIL mid_rst_b seg=%b an=%b dp=%b want all 1", ifb.seg, ifb.an, ifb.dp);
        end
        checks++;
        drive(16'h5678, 4'b0000, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();
        if (ifa.seg !== 7'b1111110 || ifa.an !== 4'b0001 || ifa.digit_idx !== 2'd0) begin
            errors++; $display("FAIL mid_first seg=%b an=%b idx=%0d want 1111110/0001/0", ifa.seg, ifa.an, ifa.digit_idx);
        end
        checks++;
        tick();
        tick();
        // Edge 4 is the terminal count: load lands together with the index advance.
        drive(16'h5678, 4'b0000, 1'b0, 1'b1);
        tick();
        drive(16'h5678, 4'b0000, 1'b0, 1'b0);
        if (ifa.seg !== 7'b1111110 || ifa.an !== 4'b0001) begin
            errors++; $display("FAIL tc_old seg=%b an=%b want 1111110/0001", ifa.seg, ifa.an);
        end
        checks++;
        tick();
        if (ifa.seg !== 7'b1110000 || ifa.an !== 4'b0010 || ifa.digit_idx !== 2'd1) begin
            errors++; $display("FAIL tc_new seg=%b an=%b idx=%0d want 1110000/0010/1", ifa.seg, ifa.an, ifa.digit_idx);
        end
        checks++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(16'h0000, 4'b0000, 1'b0, 1'b0);
        test_reset();
        test_scan();
        test_blanking();
        test_dp_blank();
        test_invalid();
        test_common_anode();
        test_reset_midscan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
